// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full adder walks the operands LSB first, one bit per clock,
// with an IDLE/ADD/DONE controller and registered sum, carry-out and overflow.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             carryout_q;
    logic             overflow_q;

    logic             bit_a;
    logic             bit_b;
    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] acc_d;

    // The single full adder; the sum bit enters at the top so bit 0 lands at LSB after WIDTH shifts.
    always_comb begin
        bit_a   = a_q[cnt_q];
        bit_b   = b_q[cnt_q];
        sum_bit = bit_a ^ bit_b ^ carry_q;
        carry_d = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
        acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carryin;
                        cnt_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // carry_q here is still the carry into the MSB
                        sum_q      <= acc_d;
                        carryout_q <= carry_d;
                        overflow_q <= carry_q ^ carry_d;
                        cnt_q      <= '0;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q == ADD);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: an 8-bit instance for directed vectors and a 4-bit instance swept over all inputs.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start8, c8, busy8, done8, co8, ov8;
    logic [7:0] a8, b8, sum8;
    logic       start4, c4, busy4, done4, co4, ov4;
    logic [3:0] a4, b4, sum4;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .carryin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .carryout(co8), .overflow(ov8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .carryin(c4),
        .busy(busy4), .done(done4), .sum(sum4), .carryout(co4), .overflow(ov4)
    );

    typedef struct {
        int s;
        int co;
        int ov;
        int cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon8();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && done8) begin
                if (q8.size() == 0) begin
                    chk("w8_unexpected_done", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("w8_sum", int'(sum8), e.s);
                    chk("w8_carryout", int'(co8), e.co);
                    chk("w8_overflow", int'(ov8), e.ov);
                    chk("w8_done_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic mon4();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && done4) begin
                if (q4.size() == 0) begin
                    chk("w4_unexpected_done", 1, 0);
                end else begin
                    e = q4.pop_front();
                    chk("w4_sum", int'(sum4), e.s);
                    chk("w4_carryout", int'(co4), e.co);
                    chk("w4_overflow", int'(ov4), e.ov);
                    chk("w4_done_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    // Waits for IDLE at a falling edge, drives the operands, and returns just after the accepting edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input int es, input int eco, input int eov, input bit push);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy8 && !done8) ok = 1'b1;
        end
        if (!ok) chk("w8_idle_wait", 0, 1);
        a8 = av; b8 = bv; c8 = cv; start8 = 1'b1;
        e.s = es; e.co = eco; e.ov = eov; e.cyc = cyc + 1 + 8;
        if (push) q8.push_back(e);
        @(posedge clk);
    endtask

    task automatic issue4(input int av, input int bv, input int cv);
        exp_t e;
        bit   ok;
        int   full;
        int   sa, sb, ss;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy4 && !done4) ok = 1'b1;
        end
        if (!ok) chk("w4_idle_wait", 0, 1);
        a4 = 4'(av); b4 = 4'(bv); c4 = 1'(cv); start4 = 1'b1;
        full = av + bv + cv;
        sa = (av >> 3) & 1;
        sb = (bv >> 3) & 1;
        ss = (full >> 3) & 1;
        e.s   = full & 15;
        e.co  = (full >> 4) & 1;
        e.ov  = (sa == sb && ss != sa) ? 1 : 0;
        e.cyc = cyc + 1 + 4;
        q4.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        fork
            mon8();
            mon4();
        join_none

        #12;
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_sum8", int'(sum8), 0);
        chk("rst_co8", int'(co8), 0);
        chk("rst_ov8", int'(ov8), 0);
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_done4", int'(done4), 0);
        chk("rst_sum4", int'(sum4), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // zero operands, with the busy window and the done pulse traced cycle by cycle
        issue8(8'h00, 8'h00, 1'b0, 8'h00, 0, 0, 1'b1);
        #1 start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("w8_busy_window", int'(busy8), 1);
            chk("w8_done_early", int'(done8), 0);
        end
        @(negedge clk);
        chk("w8_busy_after", int'(busy8), 0);
        chk("w8_done_pulse", int'(done8), 1);
        @(negedge clk);
        chk("w8_done_single", int'(done8), 0);

        // corner vectors launched back-to-back with start held high
        issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1, 0, 1'b1);
        issue8(8'h7F, 8'h01, 1'b0, 8'h80, 0, 1, 1'b1);
        issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1, 0, 1'b1);
        issue8(8'h80, 8'h80, 1'b0, 8'h00, 1, 1, 1'b1);
        #1 start8 = 1'b0;

        // start re-pulsed mid-addition with new operands must be ignored
        issue8(8'h12, 8'h34, 1'b0, 8'h46, 0, 0, 1'b1);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;

        // reset in the middle of an addition aborts it
        issue8(8'h12, 8'h34, 1'b0, 0, 0, 0, 1'b0);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        chk("abort_sum", int'(sum8), 0);
        chk("abort_co", int'(co8), 0);
        chk("abort_ov", int'(ov8), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(done8), 0);
        end
        issue8(8'h0F, 8'h01, 1'b0, 8'h10, 0, 0, 1'b1);
        #1 start8 = 1'b0;

        // exhaustive 4-bit sweep, back-to-back
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    issue4(ia, ib, ic);
        #1 start4 = 1'b0;

        for (int i = 0; i < 100 && (q8.size() != 0 || q4.size() != 0); i++)
            @(negedge clk);
        chk("w8_pending_results", q8.size(), 0);
        chk("w4_pending_results", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
